// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared types and width helpers for the FFT butterfly scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

  // Width of the stage index; never narrower than one bit.
  function automatic int stage_w(input int log2_n);
    return (log2_n > 1) ? $clog2(log2_n) : 1;
  endfunction

  // Width of the butterfly index and the twiddle index (N/2 values each).
  function automatic int coef_w(input int log2_n);
    return (log2_n > 1) ? log2_n - 1 : 1;
  endfunction

  // Width of a counter holding 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return (max_out > 0) ? $clog2(max_out + 1) : 1;
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: combinational decimation-in-time address generator.
// Maps (stage s, butterfly k) to operand addresses a, b and twiddle index.
module fft_bfly_addr_gen
  import fft_sched_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic [stage_w(LOG2_N)-1:0] stage,
  input  logic [coef_w(LOG2_N)-1:0]  k,
  output logic [LOG2_N-1:0]          idx_a,
  output logic [LOG2_N-1:0]          idx_b,
  output logic [coef_w(LOG2_N)-1:0]  coef
);

  localparam int SW = stage_w(LOG2_N);
  localparam int CW = coef_w(LOG2_N);

  logic [LOG2_N-1:0] k_ext;
  logic [LOG2_N-1:0] half;
  logic [LOG2_N-1:0] group;
  logic [LOG2_N-1:0] pos;
  logic [SW-1:0]     coef_shift;

  // Split k into group and in-group position; a = group*2h + pos, b = a + h.
  always_comb begin
    k_ext      = LOG2_N'(k);
    half       = LOG2_N'(1) << stage;
    group      = k_ext >> stage;
    pos        = k_ext & (half - 1'b1);
    idx_a      = ((group << stage) << 1) | pos;
    idx_b      = idx_a | half;
    coef_shift = SW'(LOG2_N - 1) - stage;
    coef       = CW'(pos) << coef_shift;
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: issues every radix-2 butterfly of a 2^LOG2_N-point FFT
// in DIT order, draining in-flight butterflies before each stage advance.
// Optional feature: define FFT_SCHED_ERR_EN for the sticky protocol error flag.
module fft_bfly_scheduler
  import fft_sched_pkg::*;
#(
  parameter int LOG2_N          = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       frame_valid_i,
  output logic                       frame_ready_o,
  output logic                       bfly_valid_o,
  input  logic                       bfly_ready_i,
  output logic [stage_w(LOG2_N)-1:0] bfly_stage_o,
  output logic [LOG2_N-1:0]          bfly_idx_a_o,
  output logic [LOG2_N-1:0]          bfly_idx_b_o,
  output logic [coef_w(LOG2_N)-1:0]  bfly_coef_o,
  input  logic                       bfly_done_i,
  output logic                       frame_done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int SW = stage_w(LOG2_N);
  localparam int CW = coef_w(LOG2_N);
  localparam int OW = cnt_w(MAX_OUTSTANDING);

  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);
  localparam logic [CW-1:0] LAST_K     = CW'((1 << (LOG2_N - 1)) - 1);
  localparam logic [OW-1:0] MAX_OUT    = OW'(MAX_OUTSTANDING);

  sched_state_e state_q;
  sched_state_e state_d;
  logic [SW-1:0] stage_q;
  logic [CW-1:0] k_q;
  logic [OW-1:0] outstanding_q;

  logic          can_issue;
  logic          handshake;
  logic          done_take;
  logic          drain_empty;
  logic [LOG2_N-1:0] gen_a;
  logic [LOG2_N-1:0] gen_b;
  logic [CW-1:0]     gen_coef;

  assign can_issue   = (state_q == ST_ISSUE) && (outstanding_q < MAX_OUT);
  assign handshake   = can_issue && bfly_ready_i;
  assign done_take   = bfly_done_i && (outstanding_q != '0);
  assign drain_empty = (state_q == ST_DRAIN) && (outstanding_q == '0);

  fft_bfly_addr_gen #(
    .LOG2_N(LOG2_N)
  ) u_addr_gen (
    .stage (stage_q),
    .k     (k_q),
    .idx_a (gen_a),
    .idx_b (gen_b),
    .coef  (gen_coef)
  );

  // Command fields read as zero whenever no command is being offered.
  assign bfly_valid_o = can_issue;
  assign bfly_stage_o = can_issue ? stage_q  : '0;
  assign bfly_idx_a_o = can_issue ? gen_a    : '0;
  assign bfly_idx_b_o = can_issue ? gen_b    : '0;
  assign bfly_coef_o  = can_issue ? gen_coef : '0;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    state_d       = state_q;
    frame_ready_o = 1'b0;
    frame_done_o  = 1'b0;
    busy_o        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        frame_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (frame_valid_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (handshake && (k_q == LAST_K)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) state_d = (stage_q == LAST_STAGE) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly index advances per accepted command; stage advances once drained.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
      k_q     <= '0;
    end else begin
      if (handshake) k_q <= (k_q == LAST_K) ? '0 : k_q + 1'b1;
      if (drain_empty && (stage_q != LAST_STAGE)) stage_q <= stage_q + 1'b1;
      else if (state_q == ST_DONE)                 stage_q <= '0;
    end
  end

  // In-flight count: a simultaneous issue and completion cancel out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     outstanding_q <= '0;
    else if (handshake && !done_take) outstanding_q <= outstanding_q + 1'b1;
    else if (done_take && !handshake) outstanding_q <= outstanding_q - 1'b1;
  end

`ifdef FFT_SCHED_ERR_EN
  logic err_q;

  // Sticky flag for stray completions and frame requests while busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else if ((bfly_done_i && (outstanding_q == '0)) ||
             (frame_valid_i && (state_q != ST_IDLE))) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/fft_bfly_scheduler.md
# fft_bfly_scheduler

Control sequencer for a shared radix-2 butterfly datapath in the 2^LOG2_N-point FFT pipeline. It accepts one frame start at a time and issues every butterfly of every stage in decimation-in-time order, with operand indices and twiddle index. It enforces the inter-stage data hazard by draining all in-flight butterflies before advancing a stage, and signals frame completion.

## Interface
- LOG2_N, 3, log2 of FFT size; N = 2^LOG2_N, N/2 butterflies per stage, LOG2_N stages
- MAX_OUTSTANDING, 4, max issued-but-not-completed butterflies; range 1..N/2
- clk_i  in  1  clock; all logic rising-edge
- rst_n_i  in  1  reset, asynchronous, active-low; one clock domain
- frame_valid_i  in  1  request to start processing the buffered frame
- frame_ready_o  out  1  scheduler idle, can accept a frame
- bfly_valid_o  out  1  butterfly command valid
- bfly_ready_i  in  1  datapath accepts command
- bfly_stage_o  out  $clog2(LOG2_N)  stage index s
- bfly_idx_a_o  out  LOG2_N  upper operand address
- bfly_idx_b_o  out  LOG2_N  lower operand address
- bfly_coef_o  out  LOG2_N-1  twiddle ROM index
- bfly_done_i  in  1  one-cycle pulse per completed butterfly (write-back done)
- frame_done_o  out  1  one-cycle pulse, frame finished
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE; counters stage s, butterfly k (0..N/2-1), outstanding (0..MAX_OUTSTANDING).
- IDLE: frame_ready_o=1. frame_valid_i&&frame_ready_o -> ISSUE, s=0, k=0.
- ISSUE: bfly_valid_o = (outstanding < MAX_OUTSTANDING). Handshake (valid&&ready): k++, outstanding++. Handshake at k=N/2-1 -> DRAIN, k=0.
- DRAIN: bfly_valid_o=0. outstanding==0: s==LOG2_N-1 -> DONE, else s++ and -> ISSUE.
- DONE: frame_done_o=1 for exactly one cycle -> IDLE.
- bfly_done_i: outstanding--. Handshake and done in same cycle: outstanding unchanged. done with outstanding==0: ignored (counter saturates at 0).
- Address gen, h=2^s: group=k>>s, pos=k&(h-1), a=group*2h+pos, b=a+h, coef=pos<<(LOG2_N-1-s). Unsigned, widths as ports, no overflow possible.
- Command outputs hold stable while bfly_valid_o=1 and bfly_ready_i=0. bfly_valid_o never drops without a handshake unless reset.
- frame_valid_i outside IDLE ignored.
- Reset mid-frame: all state cleared immediately. In-flight bfly_done_i pulses after reset are ignored.

## Timing
- All outputs decode from registers only; no input-to-output combinational path.
- Reset values: frame_ready_o=1, bfly_valid_o=0, bfly_stage_o/idx_a/idx_b/coef=0, frame_done_o=0, busy_o=0, err_o=0.
- Frame accepted at edge T. First command valid in T+1.
- DRAIN exits the cycle after outstanding reaches 0. Next stage's first command is 2 cycles after the last done pulse.
- Reference case, LOG2_N=3, MAX_OUTSTANDING=4, bfly_ready_i=1, done 1 cycle after handshake:
  - Stage starts at T+1, T+7, T+13.
  - frame_done_o in T+19.
  - frame_ready_o=1 again in T+20.

## Configuration
- FFT_SCHED_ERR_EN defined: err_o sets on bfly_done_i with outstanding==0, or frame_valid_i while busy. Cleared only by reset.
- Not defined: err_o tied 0 and no error logic is synthesised. All other behaviour is identical.

## Structure
- Package fft_sched_pkg holds:
  - the state enum typedef
  - helper functions for widths derived from LOG2_N.
- Sub-module fft_bfly_addr_gen: purely combinational (s, k) -> (a, b, coef). It is instantiated once and reused by the bench as a golden model.
- Top holds the FSM, counters and handshake logic.

## Test plan
- Reference case above -> 12 commands in order:
  - s0: (0,1,0),(2,3,0),(4,5,0),(6,7,0)
  - s1: (0,2,0),(1,3,2),(4,6,0),(5,7,2)
  - s2: (0,4,0),(1,5,1),(2,6,2),(3,7,3)
  - frame_done_o in T+19.
- bfly_ready_i low for 3 cycles mid-stage -> command held stable, no index skipped or repeated.
- MAX_OUTSTANDING=1, done latency 5 -> never 2 in flight; bfly_valid_o low while waiting.
- Handshake and done in the same cycle with outstanding=2 -> outstanding stays 2.
- rst_n_i asserted during stage 1 -> next cycle all outputs at reset values. A new frame restarts at s0,k0.
- FFT_SCHED_ERR_EN defined, spurious bfly_done_i in IDLE -> err_o=1 and stays 1. Macro undefined -> err_o stays 0.
